// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU tile sequencer slice.
//   - seq_state_e   : sequencer FSM state encoding
//   - TPU_* consts  : default datapath widths and pipeline latency
// Optional feature macro used by tpu_tile_sequencer: TPU_SEQ_PERF_EN.
// ---------------------------------------------------------------------------
package tpu_pkg;

  localparam int unsigned TPU_MATRIX_SIZE    = 8;
  localparam int unsigned TPU_NUM_PE_ROWS    = 8;
  localparam int unsigned TPU_ADDRESSSIZE    = 10;
  localparam int unsigned TPU_PARTIAL_SUM_BW = 19;
  localparam int unsigned TPU_VEC_CNT_BW     = 10;
  localparam int unsigned TPU_TILE_CNT_BW    = 4;
  // Address issue to array output: skew across the matrix plus row depth.
  localparam int unsigned TPU_PIPE_LAT       = TPU_MATRIX_SIZE + TPU_NUM_PE_ROWS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_W = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_RELOAD = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_e;

endpackage : tpu_pkg

// File: rtl/tpu_tag_delay.sv
// ---------------------------------------------------------------------------
// tpu_tag_delay
// Fixed-depth shift register carrying {live, tile, vec} tags alongside the
// systolic array pipeline. The MSB of each entry is the live flag.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   flush       : synchronous clear of every stage (wins over shifting)
//   din         : tag entering the pipe this cycle
//   dout        : tag leaving the pipe (issued DEPTH cycles earlier)
//   any_live    : some stage currently holds a live entry
// ---------------------------------------------------------------------------
module tpu_tag_delay #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_live
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    any_live = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) any_live = any_live | stage_q[i][WIDTH-1];
  end

  assign dout = stage_q[DEPTH-1];

endmodule : tpu_tag_delay

// File: rtl/tpu_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_tile_sequencer
// Runs a job of N weight tiles x M input vectors from one start pulse:
// per tile it pops the weight FIFO, pulses weight reload, streams M UB
// addresses, drains the array pipeline, and tags results with tile/vector.
// Ports:
//   clk, rstn                    : clock, asynchronous active-low reset
//   start, abort                 : job start (IDLE only) / synchronous cancel
//   cfg_base_addr/num_vectors/num_tiles : job config, latched on start
//   fifo_empty / fifo_read_enable: weight FIFO status / one-cycle pop
//   we_rl                        : one-cycle systolic weight reload
//   sram_address, valid_address  : UB read address and its issue strobe
//   array_result                 : systolic array output
//   res_valid/res_data/res_tile/res_vec : registered, tagged result row
//   busy, end_                   : FSM not idle / job-complete pulse
// Optional (TPU_SEQ_PERF_EN): perf_busy_cycles, perf_stall_cycles.
// ---------------------------------------------------------------------------
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned ADDRESSSIZE    = TPU_ADDRESSSIZE,
  parameter int unsigned NUM_PE_ROWS    = TPU_NUM_PE_ROWS,
  parameter int unsigned PARTIAL_SUM_BW = TPU_PARTIAL_SUM_BW,
  parameter int unsigned VEC_CNT_BW     = TPU_VEC_CNT_BW,
  parameter int unsigned TILE_CNT_BW    = TPU_TILE_CNT_BW,
  parameter int unsigned PIPE_LAT       = TPU_PIPE_LAT
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [ADDRESSSIZE-1:0]                cfg_base_addr,
  input  logic [VEC_CNT_BW-1:0]                 cfg_num_vectors,
  input  logic [TILE_CNT_BW-1:0]                cfg_num_tiles,
  input  logic                                  fifo_empty,
  output logic                                  fifo_read_enable,
  output logic                                  we_rl,
  output logic [ADDRESSSIZE-1:0]                sram_address,
  output logic                                  valid_address,
  input  logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] array_result,
  output logic                                  res_valid,
  output logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] res_data,
  output logic [TILE_CNT_BW-1:0]                res_tile,
  output logic [VEC_CNT_BW-1:0]                 res_vec,
  output logic                                  busy,
  output logic                                  end_
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0]                           perf_busy_cycles,
  output logic [31:0]                           perf_stall_cycles
`endif
);

  localparam int unsigned TAG_W = 1 + TILE_CNT_BW + VEC_CNT_BW;

  seq_state_e state_q, state_d;

  logic [ADDRESSSIZE-1:0] base_q;
  logic [VEC_CNT_BW-1:0]  nvec_q;
  logic [TILE_CNT_BW-1:0] ntile_q;
  logic [VEC_CNT_BW-1:0]  vec_q, vec_d;
  logic [TILE_CNT_BW-1:0] tile_q, tile_d;

  logic                   start_acc;
  logic                   flush;
  logic [TAG_W-1:0]       tag_in, tag_out;
  logic                   tag_live;
  logic                   tag_valid;

  logic                                  res_valid_q;
  logic [PARTIAL_SUM_BW*NUM_PE_ROWS-1:0] res_data_q;
  logic [TILE_CNT_BW-1:0]                res_tile_q;
  logic [VEC_CNT_BW-1:0]                 res_vec_q;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign flush     = abort && (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // FSM next state and Moore outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    vec_d            = vec_q;
    tile_d           = tile_q;
    fifo_read_enable = 1'b0;
    we_rl            = 1'b0;
    valid_address    = 1'b0;
    sram_address     = '0;
    end_             = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_W;
          vec_d   = '0;
          tile_d  = '0;
        end
      end
      ST_WAIT_W: begin
        // Zero-sized jobs are detected here, once the counts are latched.
        if ((nvec_q == '0) || (ntile_q == '0)) state_d = ST_DONE;
        else if (!fifo_empty)                  state_d = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        fifo_read_enable = 1'b1;
        state_d          = ST_RELOAD;
      end
      ST_RELOAD: begin
        we_rl   = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        valid_address = 1'b1;
        sram_address  = base_q + ADDRESSSIZE'(vec_q);
        if (vec_q == nvec_q - VEC_CNT_BW'(1)) state_d = ST_DRAIN;
        else                                  vec_d   = vec_q + VEC_CNT_BW'(1);
      end
      ST_DRAIN: begin
        if (!tag_live) begin
          if (tile_q < ntile_q - TILE_CNT_BW'(1)) begin
            tile_d  = tile_q + TILE_CNT_BW'(1);
            vec_d   = '0;
            state_d = ST_WAIT_W;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        end_    = !abort;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any transition; the LOAD_W pop above still happens.
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tile_q  <= tile_d;
    end
  end

  // Config is frozen for the whole job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q  <= '0;
      nvec_q  <= '0;
      ntile_q <= '0;
    end else if (start_acc) begin
      base_q  <= cfg_base_addr;
      nvec_q  <= cfg_num_vectors;
      ntile_q <= cfg_num_tiles;
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline and result capture
  // -------------------------------------------------------------------------
  assign tag_in = {valid_address, tile_q, vec_q};

  tpu_tag_delay #(
    .WIDTH (TAG_W),
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .din      (tag_in),
    .dout     (tag_out),
    .any_live (tag_live)
  );

  assign tag_valid = tag_out[TAG_W-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tile_q  <= '0;
      res_vec_q   <= '0;
    end else begin
      res_valid_q <= tag_valid && !flush;
      if (tag_valid && !flush) begin
        res_data_q <= array_result;
        res_tile_q <= tag_out[VEC_CNT_BW +: TILE_CNT_BW];
        res_vec_q  <= tag_out[VEC_CNT_BW-1:0];
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tile  = res_tile_q;
  assign res_vec   = res_vec_q;

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (start_acc) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy) perf_busy_q <= perf_busy_q + 32'd1;
      if ((state_q == ST_WAIT_W) && fifo_empty) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule : tpu_tile_sequencer

// File: tb/tb_tpu_tile_sequencer.sv
module tb_tpu_tile_sequencer;

  localparam int AW   = 10;
  localparam int ROWS = 8;
  localparam int PSB  = 19;
  localparam int VB   = 10;
  localparam int TB   = 4;
  localparam int LAT  = 16;
  localparam int RW   = PSB * ROWS;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [AW-1:0]   cfg_base_addr = '0;
  logic [VB-1:0]   cfg_num_vectors = '0;
  logic [TB-1:0]   cfg_num_tiles = '0;
  logic            fifo_empty = 1'b0;
  logic            fifo_read_enable, we_rl, valid_address, res_valid, busy, end_;
  logic [AW-1:0]   sram_address;
  logic [RW-1:0]   array_result, res_data;
  logic [TB-1:0]   res_tile;
  logic [VB-1:0]   res_vec;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]     perf_busy_cycles, perf_stall_cycles;
`endif

  tpu_tile_sequencer #(
    .ADDRESSSIZE    (AW),
    .NUM_PE_ROWS    (ROWS),
    .PARTIAL_SUM_BW (PSB),
    .VEC_CNT_BW     (VB),
    .TILE_CNT_BW    (TB),
    .PIPE_LAT       (LAT)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .abort            (abort),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_num_vectors  (cfg_num_vectors),
    .cfg_num_tiles    (cfg_num_tiles),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .we_rl            (we_rl),
    .sram_address     (sram_address),
    .valid_address    (valid_address),
    .array_result     (array_result),
    .res_valid        (res_valid),
    .res_data         (res_data),
    .res_tile         (res_tile),
    .res_vec          (res_vec),
    .busy             (busy),
    .end_             (end_)
`ifdef TPU_SEQ_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Known per-address pattern the array model presents for each issued address.
  function automatic logic [RW-1:0] arr_word(input logic [AW-1:0] a);
    logic [RW-1:0] w;
    w = '0;
    for (int i = 0; i < ROWS; i++) w[i*PSB +: PSB] = {4'(i), 5'h15, a};
    return w;
  endfunction

  // Systolic array model: address issued at t shows its row at t+LAT.
  logic [AW-1:0] apipe [LAT];
  logic          avld  [LAT];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) begin apipe[i] <= '0; avld[i] <= 1'b0; end
    end else begin
      apipe[0] <= sram_address;
      avld[0]  <= valid_address;
      for (int i = 1; i < LAT; i++) begin apipe[i] <= apipe[i-1]; avld[i] <= avld[i-1]; end
    end
  end
  assign array_result = avld[LAT-1] ? arr_word(apipe[LAT-1]) : '1;

  // Scoreboard
  typedef struct packed {
    logic [TB-1:0] t;
    logic [VB-1:0] v;
    logic [RW-1:0] d;
  } res_t;

  logic [AW-1:0] exp_addr [$];
  res_t          exp_res  [$];

  int pop_cnt, rl_cnt, end_cnt, va_cnt, res_cnt;
  int pop_cyc, end_cyc, last_res_cyc;

  always @(negedge clk) begin
    if (valid_address) begin
      va_cnt++;
      if (exp_addr.size() == 0) check("unexpected_addr", RW'(sram_address), '0);
      else check("sram_address", RW'(sram_address), RW'(exp_addr.pop_front()));
    end
    if (res_valid) begin
      res_t e;
      res_cnt++;
      last_res_cyc = cyc;
      if (exp_res.size() == 0) check("unexpected_res_valid", RW'(res_valid), '0);
      else begin
        e = exp_res.pop_front();
        check("res_tile", RW'(res_tile), RW'(e.t));
        check("res_vec",  RW'(res_vec),  RW'(e.v));
        check("res_data", res_data, e.d);
      end
    end
    if (fifo_read_enable) begin pop_cnt++; pop_cyc = cyc; end
    if (we_rl) rl_cnt++;
    if (end_) begin end_cnt++; end_cyc = cyc; end
  end

  task automatic clear_stats();
    pop_cnt = 0; rl_cnt = 0; end_cnt = 0; va_cnt = 0; res_cnt = 0;
    pop_cyc = -1; end_cyc = -1; last_res_cyc = -1;
  endtask

  // Drives one start pulse; returns the cycle in which start was high.
  task automatic do_start(input logic [AW-1:0] base, input logic [VB-1:0] m,
                          input logic [TB-1:0] n, output int s_cyc);
    cfg_base_addr = base; cfg_num_vectors = m; cfg_num_tiles = n;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_job(input logic [AW-1:0] base, input int m, input int n);
    res_t r;
    for (int t = 0; t < n; t++)
      for (int v = 0; v < m; v++) begin
        logic [AW-1:0] a;
        a = base + AW'(v);
        exp_addr.push_back(a);
        r.t = TB'(t); r.v = VB'(v); r.d = arr_word(a);
        exp_res.push_back(r);
      end
  endtask

  task automatic wait_idle(output int idle_cyc);
    idle_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) begin idle_cyc = cyc; break; end
    end
    if (idle_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: busy still %0b after 400 cycles, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_addr_queue_left"}, RW'(exp_addr.size()), '0);
    check({tag, "_res_queue_left"},  RW'(exp_res.size()),  '0);
  endtask

  int s, idle;

  initial begin
    clear_stats();
    // ---------------- reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", RW'(busy), '0);
    check("rst_end", RW'(end_), '0);
    check("rst_pop", RW'(fifo_read_enable), '0);
    check("rst_valid_address", RW'(valid_address), '0);
    check("rst_res_valid", RW'(res_valid), '0);
    check("rst_res_data", res_data, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // ---------------- base wrap job: M=3, N=2
    clear_stats();
    fifo_empty = 1'b0;
    push_job(10'h3FE, 3, 2);
    do_start(10'h3FE, 10'd3, 4'd2, s);
    wait_idle(idle);
    check("wrap_pops", RW'(pop_cnt), RW'(2));
    check("wrap_reloads", RW'(rl_cnt), RW'(2));
    check("wrap_results", RW'(res_cnt), RW'(6));
    check("wrap_end_count", RW'(end_cnt), RW'(1));
    check("wrap_end_after_last_res", RW'(end_cyc), RW'(last_res_cyc + 1));
    check("wrap_busy_drop", RW'(idle), RW'(end_cyc + 1));
    check_drained("wrap");

    // ---------------- FIFO empty for 5 cycles after start
    clear_stats();
    fifo_empty = 1'b1;
    push_job(10'h010, 1, 1);
    do_start(10'h010, 10'd1, 4'd1, s);
    repeat (5) @(posedge clk);
    #1;
    check("stall_no_pop", RW'(pop_cnt), '0);
    check("stall_busy", RW'(busy), RW'(1));
    fifo_empty = 1'b0;
    wait_idle(idle);
    check("stall_pop_cycle", RW'(pop_cyc), RW'(s + 7));
    check("stall_pops", RW'(pop_cnt), RW'(1));
    check("stall_end_cycle", RW'(end_cyc), RW'(s + 27));
`ifdef TPU_SEQ_PERF_EN
    check("perf_stall_cycles", RW'(perf_stall_cycles), RW'(5));
    check("perf_busy_cycles", RW'(perf_busy_cycles), RW'(27));
`endif
    check_drained("stall");

    // ---------------- zero-sized jobs
    clear_stats();
    do_start(10'h055, 10'd0, 4'd2, s);
    wait_idle(idle);
    check("m0_end_cycle", RW'(end_cyc), RW'(s + 2));
    check("m0_pops", RW'(pop_cnt), '0);
    check("m0_valid_addr", RW'(va_cnt), '0);
    clear_stats();
    do_start(10'h055, 10'd3, 4'd0, s);
    wait_idle(idle);
    check("n0_end_cycle", RW'(end_cyc), RW'(s + 2));
    check("n0_pops", RW'(pop_cnt), '0);
    check("n0_valid_addr", RW'(va_cnt), '0);

    // ---------------- abort in STREAM, tile 0, vec 1
    clear_stats();
    exp_addr.push_back(10'h100);
    exp_addr.push_back(10'h101);
    do_start(10'h100, 10'd4, 4'd2, s);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid_next", RW'(valid_address), '0);
    check("abort_busy_next", RW'(busy), '0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_pops", RW'(pop_cnt), RW'(1));
    check("abort_end", RW'(end_cnt), '0);
    check("abort_results", RW'(res_cnt), '0);
    check("abort_valid_count", RW'(va_cnt), RW'(2));
    check_drained("abort");

    // ---------------- start while busy with new cfg is ignored
    clear_stats();
    push_job(10'h020, 2, 1);
    do_start(10'h020, 10'd2, 4'd1, s);
    repeat (5) @(posedge clk);
    #1;
    cfg_base_addr = 10'h200; cfg_num_vectors = 10'd5; cfg_num_tiles = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(idle);
    repeat (5) @(posedge clk);
    #1;
    check("ignored_start_busy", RW'(busy), '0);
    check("ignored_start_pops", RW'(pop_cnt), RW'(1));
    check("ignored_start_results", RW'(res_cnt), RW'(2));
    check("ignored_start_end", RW'(end_cnt), RW'(1));
    check_drained("ignored_start");

    // ---------------- reset mid-DRAIN, then clean job
    clear_stats();
    exp_addr.push_back(10'h030);
    exp_addr.push_back(10'h031);
    do_start(10'h030, 10'd2, 4'd1, s);
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    #2;
    check("midrst_busy", RW'(busy), '0);
    check("midrst_valid_address", RW'(valid_address), '0);
    check("midrst_sram_address", RW'(sram_address), '0);
    check("midrst_res_valid", RW'(res_valid), '0);
    check("midrst_res_data", res_data, '0);
    check("midrst_res_tag", RW'({res_tile, res_vec}), '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_end", RW'(end_cnt), '0);
    check("midrst_no_results", RW'(res_cnt), '0);
    check_drained("midrst");
    clear_stats();
    push_job(10'h3FF, 2, 1);
    do_start(10'h3FF, 10'd2, 4'd1, s);
    wait_idle(idle);
    check("post_rst_pops", RW'(pop_cnt), RW'(1));
    check("post_rst_results", RW'(res_cnt), RW'(2));
    check("post_rst_end", RW'(end_cnt), RW'(1));
    check_drained("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tpu_tile_sequencer

// File: doc/tpu_tile_sequencer.md
Name: tpu_tile_sequencer

Overview:
- Control sequencer for the systolic TPU datapath: Unified Buffer (UB), weight FIFO, systolic array and result capture.
- Runs a job of N weight tiles × M input vectors from a single start pulse.
- Per tile, in order: pops one weight tile from the FIFO, pulses weight reload, streams M consecutive UB addresses, drains the array pipeline, then tags results with tile/vector index.
- Generalises the current top level, which has no sequencing: tile count, vector count and pipeline latency become parameters/config, and it adds abort and done handshakes.

Parameters:
ADDRESSSIZE, 10, UB address width
NUM_PE_ROWS, 8, systolic rows; sets result bus width
PARTIAL_SUM_BW, 19, bits per result lane
VEC_CNT_BW, 10, width of the vector counter (max M = 2^VEC_CNT_BW-1)
TILE_CNT_BW, 4, width of the tile counter (max N = 2^TILE_CNT_BW-1)
PIPE_LAT, 16, cycles from UB address issue to matching result on the array output (≥2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
abort  in  1  synchronous job cancel
cfg_base_addr  in  ADDRESSSIZE  first UB address of the vector block
cfg_num_vectors  in  VEC_CNT_BW  M, vectors per tile
cfg_num_tiles  in  TILE_CNT_BW  N, weight tiles per job
fifo_empty  in  1  weight FIFO empty flag
fifo_read_enable  out  1  one-cycle weight FIFO pop
we_rl  out  1  one-cycle systolic weight reload
sram_address  out  ADDRESSSIZE  UB read address
valid_address  out  1  sram_address is a live issue this cycle
array_result  in  PARTIAL_SUM_BW*NUM_PE_ROWS  systolic array output
res_valid  out  1  res_data is a valid result row
res_data  out  PARTIAL_SUM_BW*NUM_PE_ROWS  registered copy of array_result
res_tile  out  TILE_CNT_BW  tile index of res_data
res_vec  out  VEC_CNT_BW  vector index of res_data
busy  out  1  high whenever the FSM is not in IDLE
end_  out  1  one-cycle job-complete pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters and delay line cleared. Reset mid-job discards the job with no end_ pulse.
- Config capture: cfg_* are registered on the accepted start. Later cfg changes do not affect the running job.
- IDLE: start=1 → WAIT_W. If either latched count is 0 → DONE instead. start while busy is ignored.
- WAIT_W: hold while fifo_empty=1. When fifo_empty=0 → LOAD_W.
- LOAD_W (1 cycle): fifo_read_enable=1 → RELOAD.
- RELOAD (1 cycle): we_rl=1 → STREAM.
- STREAM (M cycles):
  - valid_address=1; sram_address = base + vec_idx, modulo 2^ADDRESSSIZE (wraps 0x3FF→0x000).
  - After vec_idx = M-1 → DRAIN.
- DRAIN: wait until the delay line holds no live entry, i.e. PIPE_LAT cycles after the last issue. Then, if tile_idx < N-1: tile_idx++, vec_idx cleared → WAIT_W. Else → DONE.
- DONE (1 cycle): end_=1 → IDLE.
- Tiles never overlap. The next FIFO pop is strictly after the last result of the previous tile.
- Result tagging:
  - Delay line of depth PIPE_LAT carries {valid_address, tile_idx, vec_idx}.
  - At its output, res_valid/res_tile/res_vec are driven and res_data <= array_result in the same cycle.
  - Result for issue at cycle t appears at t+PIPE_LAT+1 (registered output).
- abort=1 in any non-IDLE state: → IDLE next cycle; delay line flushed; no further pops, reloads or res_valid; no end_. abort in IDLE has no effect.
- Simultaneous events:
  - abort and start in IDLE → start wins.
  - abort in LOAD_W: the pop in that cycle still occurs (the FIFO word is consumed).
- Counters are unsigned, no saturation needed: bounded by the latched cfg.

Optional Feature:
- TPU_SEQ_PERF_EN defined:
  - Adds outputs perf_busy_cycles and perf_stall_cycles, each 32-bit, unsigned, wrapping.
  - perf_busy_cycles counts cycles with busy=1; perf_stall_cycles counts WAIT_W cycles with fifo_empty=1.
  - Both are cleared on the accepted start and hold after end_.
- Not defined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package tpu_pkg: FSM state encoding (IDLE, WAIT_W, LOAD_W, RELOAD, STREAM, DRAIN, DONE), default widths (ADDRESSSIZE, PARTIAL_SUM_BW, NUM_PE_ROWS) and the PIPE_LAT default derived as MATRIX_SIZE + NUM_PE_ROWS.
- One sub-module, tpu_tag_delay: parametrised shift register, width 1+TILE_CNT_BW+VEC_CNT_BW, depth PIPE_LAT, synchronous flush, plus an any-live output used by DRAIN.

Test Plan:
- base=0x3FE, M=3, N=2, FIFO non-empty:
  - Addresses 0x3FE,0x3FF,0x000 issued twice.
  - Exactly 2 fifo_read_enable and 2 we_rl pulses.
  - 6 res_valid beats tagged (0,0..2),(1,0..2).
  - end_ one cycle after the last result; busy then drops.
- FIFO empty for 5 cycles after start:
  - Stays in WAIT_W, no pop.
  - Pop on the first cycle after fifo_empty falls; perf_stall_cycles=5 when TPU_SEQ_PERF_EN is defined.
- M=0 or N=0: end_ 2 cycles after start; zero pops, zero valid_address.
- abort during STREAM of tile 0 at vec 1 (M=4, N=2): valid_address low next cycle, no res_valid afterwards, no end_, FIFO popped exactly once.
- start asserted while busy with changed cfg: ignored; running job completes with the original addresses and counts.
- rstn low mid-DRAIN then released: all outputs 0; next start runs a full clean job.
